// File: rtl/ysyx_24120009_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ysyx_24120009_sram_slave: word-addressed SRAM target for aw/w/b/ar/r bus |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ysyx_24120009_sram_slave #(
  parameter int          DEPTH_LOG2    = 12,
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter int          READ_LATENCY  = 1,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [2:0]  slave_state_debug
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_COLLECT = 3'd1,
    W_WAIT    = 3'd2,
    W_RESP    = 3'd3,
    R_WAIT    = 3'd4,
    R_RESP    = 3'd5
  } state_t;

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [7:0] RD_LOAD = (READ_LATENCY  == 0) ? 8'd0 : 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_LOAD = (WRITE_LATENCY == 0) ? 8'd0 : 8'(WRITE_LATENCY - 1);
  localparam logic [32:0] SPAN   = 33'd1 << (DEPTH_LOG2 + 2);

  state_t                state;
  logic                  aw_got, w_got;
  logic [31:0]           aw_addr_q, w_data_q;
  logic [3:0]            w_strb_q;
  logic [7:0]            cnt;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_ok;
  logic [31:0]           mem [DEPTH];

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [31:0]           cm_addr, cm_data, cm_off, ar_off;
  logic [3:0]            cm_strb;
  logic [DEPTH_LOG2-1:0] cm_idx, ar_idx;
  logic                  cm_ok, ar_ok;
  logic                  unused_wstrb;

  assign unused_wstrb      = ^wstrb[7:4];
  assign slave_state_debug = state;

  assign awready = (state == IDLE || state == W_COLLECT) && !aw_got;
  assign wready  = (state == IDLE || state == W_COLLECT) && !w_got;
  assign arready = (state == IDLE) && !awvalid && !wvalid;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // The commit merges whichever half was captured earlier with the live half.
  always_comb begin
    cm_addr = aw_got ? aw_addr_q : awaddr;
    cm_data = w_got  ? w_data_q  : wdata;
    cm_strb = w_got  ? w_strb_q  : wstrb[3:0];
    commit  = 1'b0;
    if (state == IDLE)
      commit = aw_hs && w_hs;
    else if (state == W_COLLECT)
      commit = (aw_got && w_hs) || (w_got && aw_hs);
  end

  assign cm_off = cm_addr - BASE_ADDR;
  assign cm_idx = cm_off[DEPTH_LOG2+1:2];
  assign cm_ok  = (cm_addr >= BASE_ADDR) && ({1'b0, cm_off} < SPAN);
  assign ar_off = araddr - BASE_ADDR;
  assign ar_idx = ar_off[DEPTH_LOG2+1:2];
  assign ar_ok  = (araddr >= BASE_ADDR) && ({1'b0, ar_off} < SPAN);

  // Memory contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (!rst && commit && cm_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (cm_strb[i]) mem[cm_idx][8*i +: 8] <= cm_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      cnt    <= 8'd0;
      bvalid <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= 32'd0;
      rd_ok  <= 1'b0;
    end else if (commit) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      if (WRITE_LATENCY == 0) begin
        bvalid <= 1'b1;
        state  <= W_RESP;
      end else begin
        cnt   <= WR_LOAD;
        state <= W_WAIT;
      end
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            aw_got    <= 1'b1;
            aw_addr_q <= awaddr;
            state     <= W_COLLECT;
          end else if (w_hs) begin
            w_got    <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb[3:0];
            state    <= W_COLLECT;
          end else if (ar_hs) begin
            rd_idx <= ar_idx;
            rd_ok  <= ar_ok;
            cnt    <= RD_LOAD;
            state  <= R_WAIT;
          end
        end
        W_COLLECT: ;
        W_WAIT: begin
          if (cnt == 8'd0) begin
            bvalid <= 1'b1;
            state  <= W_RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        R_WAIT: begin
          if (cnt == 8'd0) begin
            rdata  <= rd_ok ? mem[rd_idx] : 32'd0;
            rvalid <= 1'b1;
            state  <= R_RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24120009_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ysyx_24120009_sram_slave: directed bench with a transaction-level model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ysyx_24120009_sram_slave;
  localparam int          RL   = 3;
  localparam int          WL   = 1;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
  logic [7:0]  wstrb = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] rdata;
  logic [2:0]  slave_state_debug;

  int checks = 0, errors = 0;

  ysyx_24120009_sram_slave #(
    .DEPTH_LOG2(12), .BASE_ADDR(BASE), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .slave_state_debug(slave_state_debug)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level memory model: sparse word store indexed by word offset.
  logic [31:0] mm [int];

  function automatic void mcommit(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    logic [31:0] off, w;
    int idx;
    off = a - BASE;
    if (a >= BASE && off < 32'd16384) begin
      idx = int'(off >> 2);
      w = mm.exists(idx) ? mm[idx] : 32'd0;
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      mm[idx] = w;
    end
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a >= BASE && off < 32'd16384 && mm.exists(int'(off >> 2))) return mm[int'(off >> 2)];
    return 32'd0;
  endfunction

  // Bus-level expectation: kind 0 idle, 1 half a write seen, 2 write response
  // pending, 3 read response pending; due = edges left before valid rises.
  int          kind = 0, due = 0;
  logic        aw_c = 0, w_c = 0, started = 0;
  logic [31:0] m_aa = 0, m_wd = 0, r_exp = 0, last_rd = 0;
  logic [7:0]  m_ws = 0;
  logic        ex_aw, ex_w, ex_ar;
  logic [2:0]  ex_st;

  always @(negedge clk) begin
    ex_aw = (kind == 0 || kind == 1) && !aw_c;
    ex_w  = (kind == 0 || kind == 1) && !w_c;
    ex_ar = (kind == 0) && !awvalid && !wvalid;
    case (kind)
      0: ex_st = 3'd0;
      1: ex_st = 3'd1;
      2: ex_st = (due > 0) ? 3'd2 : 3'd3;
      default: ex_st = (due > 0) ? 3'd4 : 3'd5;
    endcase
    if (started) begin
      chk("awready", awready, ex_aw);
      chk("wready", wready, ex_w);
      chk("arready", arready, ex_ar);
      chk("bvalid", bvalid, kind == 2 && due == 0);
      chk("rvalid", rvalid, kind == 3 && due == 0);
      chk("rdata", rdata, (kind == 3 && due == 0) ? r_exp : last_rd);
      chk("state", slave_state_debug, ex_st);
    end
    if (rst) begin
      kind = 0; aw_c = 0; w_c = 0; last_rd = 0; started = 1;
    end else if (started) begin
      case (kind)
        0: begin
          if (awvalid && ex_aw && wvalid && ex_w) begin
            mcommit(awaddr, wdata, wstrb); kind = 2; due = WL;
          end else if (awvalid && ex_aw) begin
            aw_c = 1; m_aa = awaddr; kind = 1;
          end else if (wvalid && ex_w) begin
            w_c = 1; m_wd = wdata; m_ws = wstrb; kind = 1;
          end else if (arvalid && ex_ar) begin
            r_exp = mread(araddr); kind = 3; due = (RL == 0) ? 1 : RL;
          end
        end
        1: begin
          if ((aw_c && wvalid) || (w_c && awvalid)) begin
            if (aw_c) mcommit(m_aa, wdata, wstrb);
            else      mcommit(awaddr, m_wd, m_ws);
            aw_c = 0; w_c = 0; kind = 2; due = WL;
          end
        end
        2: if (due > 0) due--; else if (bready) kind = 0;
        default: begin
          if (due > 0) due--;
          else if (rready) begin kind = 0; last_rd = r_exp; end
        end
      endcase
    end
  end

  task automatic wait_b(input int lat_lit);
    int n;
    bready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 300);
    chk("b_latency", n - 1, lat_lit);
    @(posedge clk); #1 bready = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    int n;
    @(posedge clk); #1 awvalid = 1; wvalid = 1; awaddr = a; wdata = d; wstrb = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < 100);
    chk("aw_w_ready", awready && wready, 1'b1);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    wait_b(WL);
  endtask

  task automatic wait_ar();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 100);
    chk("ar_ready", arready, 1'b1);
    @(posedge clk); #1 arvalid = 0;
  endtask

  task automatic finish_read(input logic [31:0] lit, input int hold);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 300);
    chk("r_latency", n - 1, RL);
    chk("r_data_lit", rdata, lit);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("r_hold", {rvalid, rdata}, {1'b1, lit});
    end
    @(posedge clk); #1 rready = 1;
    @(posedge clk); #1 rready = 0;
    @(negedge clk);
    chk("r_cleared", rvalid, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold, input logic [31:0] lit);
    @(posedge clk); #1 arvalid = 1; araddr = a;
    wait_ar();
    finish_read(lit, hold);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    do_write(32'h8000_0000, 32'hDEAD_BEEF, 8'hFF);
    do_write(32'h8000_0004, 32'h1122_3344, 8'h0F);
    do_read(32'h8000_0000, 4, 32'hDEAD_BEEF);
    do_write(32'h8000_0004, 32'hAABB_CCDD, 8'h05);
    do_read(32'h8000_0004, 0, 32'h11BB_33DD);

    // W arrives alone, AW follows several cycles later
    @(posedge clk); #1 wvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 8'h0F;
    @(negedge clk); chk("split_wready", wready, 1'b1);
    @(posedge clk); #1 wvalid = 0;
    repeat (4) begin
      @(negedge clk);
      chk("split_collect", {slave_state_debug, wready}, {3'd1, 1'b0});
    end
    @(posedge clk); #1 awvalid = 1; awaddr = 32'h8000_0008;
    @(negedge clk); chk("split_awready", awready, 1'b1);
    @(posedge clk); #1 awvalid = 0;
    wait_b(WL);
    do_read(32'h8000_0008, 0, 32'hCAFE_F00D);

    // Write and read requested together: write wins
    @(posedge clk); #1 awvalid = 1; wvalid = 1; arvalid = 1;
    awaddr = 32'h8000_000C; wdata = 32'h1234_5678; wstrb = 8'hFF; araddr = 32'h8000_000C;
    @(negedge clk); chk("cont_arready", {arready, awready}, {1'b0, 1'b1});
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    wait_b(WL);
    wait_ar();
    finish_read(32'h1234_5678, 0);

    do_read(32'h7FFF_FFFC, 0, 32'h0);
    do_write(32'h9000_0000, 32'h5555_5555, 8'hFF);
    do_read(32'h8000_0000, 0, 32'hDEAD_BEEF);

    // Reset during R_WAIT
    @(posedge clk); #1 arvalid = 1; araddr = 32'h8000_0000;
    wait_ar();
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_rwait", {rvalid, bvalid, arready, rdata, slave_state_debug}, {1'b0, 1'b0, 1'b1, 32'd0, 3'd0});

    // Reset while only AW has been captured
    @(posedge clk); #1 awvalid = 1; awaddr = 32'h8000_0000; wdata = 32'h0; wstrb = 8'hFF;
    @(negedge clk); chk("rst_wc_aw", awready, 1'b1);
    @(posedge clk); #1 awvalid = 0;
    @(negedge clk); chk("rst_wc_state", slave_state_debug, 3'd1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    do_read(32'h8000_0000, 0, 32'hDEAD_BEEF);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
